// File: rtl/snake_head_ctrl_pkg.sv
// Shared snake-game definitions: direction and state encodings plus grid defaults,
// so the tick, body and render stages all agree on them.
package snake_head_ctrl_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam int GRID_W_DEF = 32;
    localparam int GRID_H_DEF = 24;

    // Opposite direction: UP<->DOWN and RIGHT<->LEFT differ only in bit 1.
    function automatic logic [1:0] reverse_of(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_dir_filter.sv
// Pending-direction register: keeps the last legal direction request,
// silently dropping 180-degree reversals of the committed direction.
module snake_dir_filter
    import snake_head_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       reload,
    input  logic       dir_valid,
    input  logic [1:0] dir_req,
    input  logic [1:0] dir,
    output logic [1:0] pend_dir
);

    // Pending direction update; a restart reload overrides any request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_dir <= DIR_RIGHT;
        end else if (reload) begin
            pend_dir <= DIR_RIGHT;
        end else if (dir_valid && (dir_req != reverse_of(dir))) begin
            pend_dir <= dir_req;
        end else begin
            pend_dir <= pend_dir;
        end
    end

endmodule

// File: rtl/snake_head_ctrl.sv
// Snake head controller: game run state, head position and committed direction,
// advancing one cell per tick with wall and self-hit detection.
module snake_head_ctrl
    import snake_head_ctrl_pkg::*;
#(
    parameter int GRID_W  = GRID_W_DEF,
    parameter int GRID_H  = GRID_H_DEF,
    parameter int X_W     = 5,
    parameter int Y_W     = 5,
    parameter int START_X = 16,
    parameter int START_Y = 12
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           tick,
    input  logic           start,
    input  logic [1:0]     dir_req,
    input  logic           dir_valid,
    input  logic           self_hit,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [1:0]     dir,
    output logic           step,
    output logic           game_over,
    output logic           running
);

    state_t         state_r;
    logic [1:0]     pend_dir_s;
    logic [X_W-1:0] next_x_s;
    logic [Y_W-1:0] next_y_s;
    logic           wall_s;
    logic           reload_s;

    assign reload_s = (state_r == ST_DEAD) && start;

    snake_dir_filter u_dir_filter (
        .clk       (clk),
        .resetn    (resetn),
        .reload    (reload_s),
        .dir_valid (dir_valid),
        .dir_req   (dir_req),
        .dir       (dir),
        .pend_dir  (pend_dir_s)
    );

    // Next cell from the pending direction; edges are flagged before any wrap.
    always_comb begin
        next_x_s = head_x;
        next_y_s = head_y;
        wall_s   = 1'b0;
        case (pend_dir_s)
            DIR_UP: begin
                if (head_y == {Y_W{1'b0}}) wall_s = 1'b1;
                else                       next_y_s = head_y - Y_W'(1);
            end
            DIR_DOWN: begin
                if (head_y == Y_W'(GRID_H - 1)) wall_s = 1'b1;
                else                            next_y_s = head_y + Y_W'(1);
            end
            DIR_LEFT: begin
                if (head_x == {X_W{1'b0}}) wall_s = 1'b1;
                else                       next_x_s = head_x - X_W'(1);
            end
            DIR_RIGHT: begin
                if (head_x == X_W'(GRID_W - 1)) wall_s = 1'b1;
                else                            next_x_s = head_x + X_W'(1);
            end
            default: begin
                wall_s = 1'b0;
            end
        endcase
    end

    // Game FSM with registered head, direction and status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            head_x    <= X_W'(START_X);
            head_y    <= Y_W'(START_Y);
            dir       <= DIR_RIGHT;
            step      <= 1'b0;
            game_over <= 1'b0;
            running   <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (self_hit || (tick && wall_s)) begin
                        state_r   <= ST_DEAD;
                        game_over <= 1'b1;
                        running   <= 1'b0;
                    end else if (tick) begin
                        head_x <= next_x_s;
                        head_y <= next_y_s;
                        dir    <= pend_dir_s;
                        step   <= 1'b1;
                    end
                end
                ST_DEAD: begin
                    if (start) begin
                        state_r   <= ST_RUN;
                        head_x    <= X_W'(START_X);
                        head_y    <= Y_W'(START_Y);
                        dir       <= DIR_RIGHT;
                        game_over <= 1'b0;
                        running   <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    game_over <= 1'b0;
                    running   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Directed bench for snake_head_ctrl: hand-computed expectations checked
// with immediate assertions after each clock edge.
module tb_snake_head_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       tick;
    logic       start;
    logic [1:0] dir_req;
    logic       dir_valid;
    logic       self_hit;
    logic [4:0] head_x;
    logic [4:0] head_y;
    logic [1:0] dir;
    logic       step;
    logic       game_over;
    logic       running;

    int tests = 0;
    int fails = 0;

    snake_head_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .tick      (tick),
        .start     (start),
        .dir_req   (dir_req),
        .dir_valid (dir_valid),
        .self_hit  (self_hit),
        .head_x    (head_x),
        .head_y    (head_y),
        .dir       (dir),
        .step      (step),
        .game_over (game_over),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs, then drop the strobes and sample 1ns after the edge.
    task automatic cyc(input logic t, input logic s, input logic v, input logic [1:0] d, input logic h);
        tick = t; start = s; dir_valid = v; dir_req = d; self_hit = h;
        @(posedge clk);
        #1;
        tick = 1'b0; start = 1'b0; dir_valid = 1'b0; dir_req = 2'd0; self_hit = 1'b0;
    endtask

    task automatic check_all(input string tag, input int x, input int y, input int d,
                             input logic st, input logic go, input logic rn);
        check({tag, ".x"},    32'(head_x),    32'(x));
        check({tag, ".y"},    32'(head_y),    32'(y));
        check({tag, ".dir"},  32'(dir),       32'(d));
        check({tag, ".step"}, 32'(step),      32'(st));
        check({tag, ".go"},   32'(game_over), 32'(go));
        check({tag, ".run"},  32'(running),   32'(rn));
    endtask

    initial begin
        resetn = 1'b0; tick = 1'b0; start = 1'b0; dir_req = 2'd0; dir_valid = 1'b0; self_hit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 16, 12, 1, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;

        // Ticks in IDLE are ignored
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check_all("idle_tick", 16, 12, 1, 1'b0, 1'b0, 1'b0);

        // 1: start and three moves to the right
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        check_all("start", 16, 12, 1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check_all("t1", 17, 12, 1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        check("t1_step_gone", 32'(step), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check_all("t2", 18, 12, 1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check_all("t3", 19, 12, 1, 1'b1, 1'b0, 1'b1);

        // 2: reversal dropped, then turn UP
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check_all("rev_drop", 20, 12, 1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check_all("turn_up", 20, 11, 0, 1'b1, 1'b0, 1'b1);

        // 3: last legal request wins; coincident request applies one tick later
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check_all("last_wins", 19, 11, 3, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
        check_all("coincident", 18, 11, 3, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check_all("coinc_next", 18, 10, 0, 1'b1, 1'b0, 1'b1);

        // 4: run into the right wall
        cyc(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        for (int i = 0; i < 13; i++) cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check_all("at_edge", 31, 10, 1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check_all("wall", 31, 10, 1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check_all("dead_tick", 31, 10, 1, 1'b0, 1'b1, 1'b0);

        // 5: request in DEAD is overridden by restart reload
        cyc(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        check_all("restart", 16, 12, 1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check_all("reload_dir", 17, 12, 1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        check_all("start_in_run", 17, 12, 1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        check_all("self_hit", 17, 12, 1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        check_all("restart2", 16, 12, 1, 1'b0, 1'b0, 1'b1);

        // Top wall: turn UP and climb from y=12 to y=0, then one more tick
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check_all("top_edge", 16, 0, 0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check_all("top_wall", 16, 0, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        check_all("restart3", 16, 12, 1, 1'b0, 1'b0, 1'b1);

        // 6: async reset right after a moving edge
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check_all("pre_rst", 17, 12, 1, 1'b1, 1'b0, 1'b1);
        resetn = 1'b0;
        #1;
        check_all("mid_rst", 16, 12, 1, 1'b0, 1'b0, 1'b0);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        check_all("rst_hold", 16, 12, 1, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
